gamma_sequencer: RTL and testbench



---
 rtl/gamma_sequencer_if.sv | 32 +++
 rtl/gamma.sv | 32 +++
 rtl/gamma_sequencer.sv | 93 +++++++++
 tb/tb_gamma_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gamma_sequencer_if.sv
// Pixel-stream handshake bundle for gamma_sequencer; bypass_i exists only when
// GAMMA_BYPASS_EN is defined.
interface gamma_sequencer_if;
  logic [23:0] pixel_i;
  logic        pixel_valid_i;
  logic        pixel_ready_o;
  logic [23:0] pixel_o;
  logic        pixel_valid_o;
  logic        pixel_ready_i;
  logic        busy_o;
`ifdef GAMMA_BYPASS_EN
  logic        bypass_i;

  modport master (
    output pixel_i, pixel_valid_i, pixel_ready_i, bypass_i,
    input  pixel_ready_o, pixel_o, pixel_valid_o, busy_o
  );
  modport slave (
    input  pixel_i, pixel_valid_i, pixel_ready_i, bypass_i,
    output pixel_ready_o, pixel_o, pixel_valid_o, busy_o
  );
`else
  modport master (
    output pixel_i, pixel_valid_i, pixel_ready_i,
    input  pixel_ready_o, pixel_o, pixel_valid_o, busy_o
  );
  modport slave (
    input  pixel_i, pixel_valid_i, pixel_ready_i,
    output pixel_ready_o, pixel_o, pixel_valid_o, busy_o
  );
`endif
endinterface

// File: rtl/gamma.sv
// 8-bit gamma-2.5 lookup table: corrected = round(255 * (code/255)^2.5).
// Table contents are folded to constants at elaboration.
module gamma (
  input  logic [7:0] code,
  output logic [7:0] corrected
);

  // Largest y with (y - 0.5)^2 <= x^5 / 255^3, i.e. the rounded square root, in integers.
  function automatic logic [7:0] gamma_calc(input int unsigned x);
    longint unsigned c, x5, lhs;
    int unsigned     y, t;
    c  = 64'(x);
    x5 = c * c * c * c * c;
    y  = 0;
    for (int b = 7; b >= 0; b--) begin
      t   = y | (32'd1 << b);
      lhs = 64'(2 * t - 1);
      lhs = lhs * lhs * 64'd16581375;
      if (lhs <= 64'd4 * x5) y = t;
    end
    return 8'(y);
  endfunction

  logic [7:0] lut [256];

  for (genvar i = 0; i < 256; i++) begin : g_lut
    assign lut[i] = gamma_calc(i);
  end

  assign corrected = lut[code];

endmodule

// File: rtl/gamma_sequencer.sv
// Shares one gamma LUT across R, G, B (one channel per clock) with a registered output.
// Optional raw-passthrough per pixel is built when GAMMA_BYPASS_EN is defined.
module gamma_sequencer (
  input  logic                clk_i,
  input  logic                reset_i,
  gamma_sequencer_if.slave    bus
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StChR  = 3'd1;
  localparam logic [2:0] StChG  = 3'd2;
  localparam logic [2:0] StChB  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [23:0] in_q;
  logic [23:0] out_q;
  logic [7:0]  lut_in;
  logic [7:0]  lut_out;
  logic [7:0]  ch_byte;
  logic        accept;

  gamma u_gamma (
    .code      (lut_in),
    .corrected (lut_out)
  );

  always_comb begin
    lut_in = in_q[23:16];
    case (state_q)
      StChG:   lut_in = in_q[15:8];
      StChB:   lut_in = in_q[7:0];
      default: lut_in = in_q[23:16];
    endcase
  end

`ifdef GAMMA_BYPASS_EN
  logic bypass_q;
  assign ch_byte = bypass_q ? lut_in : lut_out;
`else
  assign ch_byte = lut_out;
`endif

  assign bus.pixel_ready_o = !reset_i &&
                             ((state_q == StIdle) || ((state_q == StDone) && bus.pixel_ready_i));
  assign accept            = bus.pixel_ready_o && bus.pixel_valid_i;
  assign bus.pixel_valid_o = (state_q == StDone);
  // Gate to zero outside DONE so partially rewritten channels are never visible.
  assign bus.pixel_o       = (state_q == StDone) ? out_q : 24'h000000;
  assign bus.busy_o        = (state_q != StIdle);

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = bus.pixel_valid_i ? StChR : StIdle;
      StChR:   state_d = StChG;
      StChG:   state_d = StChB;
      StChB:   state_d = StDone;
      StDone: begin
        if (!bus.pixel_ready_i)     state_d = StDone;
        else if (bus.pixel_valid_i) state_d = StChR;
        else                        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      in_q     <= 24'h000000;
      out_q    <= 24'h000000;
`ifdef GAMMA_BYPASS_EN
      bypass_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        in_q     <= bus.pixel_i;
`ifdef GAMMA_BYPASS_EN
        bypass_q <= bus.bypass_i;
`endif
      end
      case (state_q)
        StChR:   out_q[23:16] <= ch_byte;
        StChG:   out_q[15:8]  <= ch_byte;
        StChB:   out_q[7:0]   <= ch_byte;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_sequencer.sv
// Directed bench for gamma_sequencer: vector table plus reset, back-to-back,
// backpressure, mid-operation reset and (GAMMA_BYPASS_EN builds) bypass sequences.
module tb_gamma_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  gamma_sequencer_if bus ();

  gamma_sequencer dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] px;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present px from IDLE (or DONE with ready) and let the accepting edge pass.
  task automatic send(input logic [23:0] px);
    @(negedge clk);
    bus.pixel_i       = px;
    bus.pixel_valid_i = 1'b1;
    #1;
    chk("accept_ready", 32'(bus.pixel_ready_o), 32'd1);
    @(posedge clk);
    #1;
    bus.pixel_valid_i = 1'b0;
  endtask

  // Negedges elapsed after the accepting edge until pixel_valid_o; capped at 10.
  task automatic wait_out(output int cyc);
    cyc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.pixel_valid_o) break;
    end
  endtask

  initial begin
    int   cyc;
    logic seen;
    checks = 0;
    errors = 0;

    vecs[0] = '{px: 24'h804020, exp: 24'h2E0801};
    vecs[1] = '{px: 24'hFFC800, exp: 24'hFF8B00};
    vecs[2] = '{px: 24'h000000, exp: 24'h000000};
    vecs[3] = '{px: 24'hFFFFFF, exp: 24'hFFFFFF};
    vecs[4] = '{px: 24'h808080, exp: 24'h2E2E2E};
    vecs[5] = '{px: 24'h204080, exp: 24'h01082E};

    reset             = 1'b1;
    bus.pixel_i       = 24'hABCDEF;
    bus.pixel_valid_i = 1'b1;
    bus.pixel_ready_i = 1'b1;
`ifdef GAMMA_BYPASS_EN
    bus.bypass_i      = 1'b0;
`endif

    // Reset held three cycles with valid asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", 32'(bus.pixel_ready_o), 32'd0);
      chk("rst_valid", 32'(bus.pixel_valid_o), 32'd0);
      chk("rst_pixel", 32'(bus.pixel_o), 32'd0);
      chk("rst_busy",  32'(bus.busy_o), 32'd0);
    end
    reset             = 1'b0;
    bus.pixel_valid_i = 1'b0;
    #1;
    chk("idle_ready", 32'(bus.pixel_ready_o), 32'd1);
    chk("idle_busy",  32'(bus.busy_o), 32'd0);

    // Table: each pixel from IDLE, latency and corrected value.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].px);
      wait_out(cyc);
      chk("latency", 32'(cyc), 32'd4);
      chk("pixel",   32'(bus.pixel_o), 32'(vecs[i].exp));
      chk("busy",    32'(bus.busy_o), 32'd1);
      @(negedge clk);
      chk("back_idle", 32'(bus.busy_o), 32'd0);
    end

    // Back-to-back through DONE with downstream always ready.
    send(24'hFFC800);
    wait_out(cyc);
    chk("b2b_lat0", 32'(cyc), 32'd4);
    chk("b2b_pix0", 32'(bus.pixel_o), 32'hFF8B00);
    bus.pixel_i       = 24'h000000;
    bus.pixel_valid_i = 1'b1;
    #1;
    chk("b2b_ready", 32'(bus.pixel_ready_o), 32'd1);
    @(posedge clk);
    #1;
    bus.pixel_valid_i = 1'b0;
    wait_out(cyc);
    chk("b2b_gap",  32'(cyc), 32'd4);
    chk("b2b_pix1", 32'(bus.pixel_o), 32'h000000);
    @(negedge clk);

    // Backpressure: six cycles held in DONE with the next pixel waiting.
    send(24'h804020);
    bus.pixel_ready_i = 1'b0;
    wait_out(cyc);
    chk("bp_lat", 32'(cyc), 32'd4);
    bus.pixel_i       = 24'hFFFFFF;
    bus.pixel_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("bp_pixel", 32'(bus.pixel_o), 32'h2E0801);
      chk("bp_valid", 32'(bus.pixel_valid_o), 32'd1);
      chk("bp_ready", 32'(bus.pixel_ready_o), 32'd0);
      @(negedge clk);
    end
    bus.pixel_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.pixel_ready_o), 32'd1);
    @(posedge clk);
    #1;
    bus.pixel_valid_i = 1'b0;
    wait_out(cyc);
    chk("bp_next_lat", 32'(cyc), 32'd4);
    chk("bp_next_pix", 32'(bus.pixel_o), 32'hFFFFFF);
    @(negedge clk);

    // Reset asserted while in CH_G aborts the pixel.
    send(24'h808080);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_chg", 32'(bus.busy_o), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.pixel_ready_o), 32'd0);
    @(negedge clk);
    chk("mid_valid", 32'(bus.pixel_valid_o), 32'd0);
    chk("mid_busy",  32'(bus.busy_o), 32'd0);
    chk("mid_pixel", 32'(bus.pixel_o), 32'd0);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.pixel_valid_o) seen = 1'b1;
    end
    chk("mid_no_output", 32'(seen), 32'd0);
    chk("mid_idle_ready", 32'(bus.pixel_ready_o), 32'd1);

`ifdef GAMMA_BYPASS_EN
    // Bypass pixel passes raw; the following corrected pixel uses the LUT again.
    bus.bypass_i = 1'b1;
    send(24'h804020);
    bus.bypass_i = 1'b0;
    wait_out(cyc);
    chk("byp_lat", 32'(cyc), 32'd4);
    chk("byp_pix", 32'(bus.pixel_o), 32'h804020);
    @(negedge clk);
    send(24'h804020);
    wait_out(cyc);
    chk("byp_off_lat", 32'(cyc), 32'd4);
    chk("byp_off_pix", 32'(bus.pixel_o), 32'h2E0801);
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
